// File: rtl/axi_lite_reg_bridge_if.sv
// AXI4-Lite slave channels plus the local register-bus strobes for axi_lite_reg_bridge.
// The slave modport is the bridge view; master covers the AXI master and register-file side.
interface axi_lite_reg_bridge_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 11
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;

    logic                  reg_write;
    logic                  reg_read;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic [STRB_W-1:0]     reg_be;
    logic                  reg_wr_err;
    logic [DATA_WIDTH-1:0] reg_rdata;
    logic                  reg_rdata_valid;
    logic                  reg_rd_err;

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        input  reg_wr_err, reg_rdata, reg_rdata_valid, reg_rd_err,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        output reg_write, reg_read, reg_addr, reg_wdata, reg_be
    );

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        output reg_wr_err, reg_rdata, reg_rdata_valid, reg_rd_err,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        input  reg_write, reg_read, reg_addr, reg_wdata, reg_be
    );
endinterface

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave to single-cycle register-bus bridge: one transaction in flight,
// round-robin between reads and writes, SLVERR on register error or read timeout.
module axi_lite_reg_bridge #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned RD_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    axi_lite_reg_bridge_if.slave bus
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = $clog2(RD_TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } state_e;

    state_e                state_q, state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic                  ar_held_q, ar_held_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic                  last_was_write_q, last_was_write_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  arready_q, arready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  reg_write_q, reg_write_d;
    logic                  reg_read_q, reg_read_d;
    logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
    logic [STRB_W-1:0]     reg_be_q, reg_be_d;

    logic wr_rdy_c;
    logic rd_rdy_c;

    // Protection attributes carry no meaning for the local register file.
    logic unused_prot;
    assign unused_prot = ^{bus.awprot, bus.arprot};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            aw_held_q        <= 1'b0;
            w_held_q         <= 1'b0;
            ar_held_q        <= 1'b0;
            aw_addr_q        <= '0;
            w_data_q         <= '0;
            w_strb_q         <= '0;
            ar_addr_q        <= '0;
            last_was_write_q <= 1'b0;
            cnt_q            <= '0;
            awready_q        <= 1'b0;
            wready_q         <= 1'b0;
            arready_q        <= 1'b0;
            bvalid_q         <= 1'b0;
            bresp_q          <= '0;
            rvalid_q         <= 1'b0;
            rdata_q          <= '0;
            rresp_q          <= '0;
            reg_write_q      <= 1'b0;
            reg_read_q       <= 1'b0;
            reg_addr_q       <= '0;
            reg_wdata_q      <= '0;
            reg_be_q         <= '0;
        end else begin
            state_q          <= state_d;
            aw_held_q        <= aw_held_d;
            w_held_q         <= w_held_d;
            ar_held_q        <= ar_held_d;
            aw_addr_q        <= aw_addr_d;
            w_data_q         <= w_data_d;
            w_strb_q         <= w_strb_d;
            ar_addr_q        <= ar_addr_d;
            last_was_write_q <= last_was_write_d;
            cnt_q            <= cnt_d;
            awready_q        <= awready_d;
            wready_q         <= wready_d;
            arready_q        <= arready_d;
            bvalid_q         <= bvalid_d;
            bresp_q          <= bresp_d;
            rvalid_q         <= rvalid_d;
            rdata_q          <= rdata_d;
            rresp_q          <= rresp_d;
            reg_write_q      <= reg_write_d;
            reg_read_q       <= reg_read_d;
            reg_addr_q       <= reg_addr_d;
            reg_wdata_q      <= reg_wdata_d;
            reg_be_q         <= reg_be_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        aw_held_d        = aw_held_q;
        w_held_d         = w_held_q;
        ar_held_d        = ar_held_q;
        aw_addr_d        = aw_addr_q;
        w_data_d         = w_data_q;
        w_strb_d         = w_strb_q;
        ar_addr_d        = ar_addr_q;
        last_was_write_d = last_was_write_q;
        cnt_d            = cnt_q;
        bresp_d          = bresp_q;
        rdata_d          = rdata_q;
        rresp_d          = rresp_q;
        reg_addr_d       = reg_addr_q;
        reg_wdata_d      = reg_wdata_q;
        reg_be_d         = reg_be_q;
        wr_rdy_c         = aw_held_q && w_held_q;
        rd_rdy_c         = ar_held_q;

        // Channel capture; ready is only ever high in IDLE with the slot empty.
        if (bus.awvalid && awready_q) begin
            aw_held_d = 1'b1;
            aw_addr_d = bus.awaddr;
        end
        if (bus.wvalid && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = bus.wdata;
            w_strb_d = bus.wstrb;
        end
        if (bus.arvalid && arready_q) begin
            ar_held_d = 1'b1;
            ar_addr_d = bus.araddr;
        end

        unique case (state_q)
            IDLE: begin
                if (wr_rdy_c && (!rd_rdy_c || !last_was_write_q)) begin
                    state_d = WR_ISSUE;
                end else if (rd_rdy_c) begin
                    state_d = RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                bresp_d          = bus.reg_wr_err ? RESP_SLVERR : RESP_OKAY;
                aw_held_d        = 1'b0;
                w_held_d         = 1'b0;
                last_was_write_d = 1'b1;
                state_d          = WR_RESP;
            end
            WR_RESP: begin
                if (bus.bready) state_d = IDLE;
            end
            RD_ISSUE: begin
                ar_held_d        = 1'b0;
                last_was_write_d = 1'b0;
                cnt_d            = '0;
                state_d          = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.reg_rdata_valid) begin
                    rdata_d = bus.reg_rdata;
                    rresp_d = bus.reg_rd_err ? RESP_SLVERR : RESP_OKAY;
                    state_d = RD_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(RD_TIMEOUT - 1)) begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                        state_d = RD_RESP;
                    end
                end
            end
            RD_RESP: begin
                if (bus.rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state implies.
        reg_write_d = (state_d == WR_ISSUE);
        reg_read_d  = (state_d == RD_ISSUE);
        if (state_d == WR_ISSUE) begin
            reg_addr_d  = aw_addr_q & ALIGN_MASK;
            reg_wdata_d = w_data_q;
            reg_be_d    = w_strb_q;
        end else if (state_d == RD_ISSUE) begin
            reg_addr_d  = ar_addr_q & ALIGN_MASK;
        end
        bvalid_d  = (state_d == WR_RESP);
        rvalid_d  = (state_d == RD_RESP);
        awready_d = !aw_held_d && (state_d == IDLE);
        wready_d  = !w_held_d  && (state_d == IDLE);
        arready_d = !ar_held_d && (state_d == IDLE);
    end

    assign bus.awready   = awready_q;
    assign bus.wready    = wready_q;
    assign bus.arready   = arready_q;
    assign bus.bvalid    = bvalid_q;
    assign bus.bresp     = bresp_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.rresp     = rresp_q;
    assign bus.reg_write = reg_write_q;
    assign bus.reg_read  = reg_read_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_be    = reg_be_q;

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Bench for axi_lite_reg_bridge: directed and random AXI-Lite traffic against a
// word-array register-file model, with expected responses and latencies computed here.
module tb_axi_lite_reg_bridge;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 11;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned RDT   = 64;
    localparam int unsigned WORDS = 1 << (AW - 2);
    localparam int          BOUND = 300;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
        int            c;
    } wr_rec_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            c;
    } rd_rec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_lite_reg_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi_lite_reg_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_TIMEOUT(RDT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit [DW-1:0] mem    [WORDS];
    bit [DW-1:0] shadow [WORDS];
    wr_rec_t     wq[$];
    rd_rec_t     rq[$];
    int          overlap  = 0;
    int          rd_delay = 1;
    int          rd_cnt   = 0;
    bit          rd_late  = 1'b0;
    logic [AW-3:0] rd_word = '0;
    bit          last_wr  = 1'b0;
    int          aw_hs, w_hs, ar_hs;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] outs();
        return 96'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.bresp, bus.rvalid,
                    bus.rdata, bus.rresp, bus.reg_write, bus.reg_read, bus.reg_addr,
                    bus.reg_wdata, bus.reg_be});
    endfunction

    // Register-file model: records strobes, holds the word array, answers reads after rd_delay.
    always @(negedge clk) begin
        if (reset) begin
            rd_cnt              = 0;
            bus.reg_rdata_valid = 1'b0;
            bus.reg_rdata       = '0;
        end else begin
            bus.reg_rdata_valid = 1'b0;
            if (bus.reg_write && bus.reg_read) overlap++;
            if (bus.reg_write) begin
                wr_rec_t r;
                r.addr = bus.reg_addr; r.data = bus.reg_wdata; r.be = bus.reg_be; r.c = cyc;
                wq.push_back(r);
                if (!bus.reg_wr_err)
                    for (int b = 0; b < int'(BW); b++)
                        if (bus.reg_be[b]) mem[bus.reg_addr[AW-1:2]][8*b +: 8] = bus.reg_wdata[8*b +: 8];
            end
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    bus.reg_rdata_valid = 1'b1;
                    bus.reg_rdata       = rd_late ? DW'(32'hDEAD_BEEF) : mem[rd_word];
                end
            end
            if (bus.reg_read) begin
                rd_rec_t r;
                r.addr = bus.reg_addr; r.c = cyc;
                rq.push_back(r);
                rd_word = bus.reg_addr[AW-1:2];
                rd_cnt  = rd_delay;
                rd_late = (rd_delay >= int'(RDT));
            end
        end
    end

    task automatic upd_shadow(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        for (int b = 0; b < int'(BW); b++)
            if (be[b]) shadow[a[AW-1:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic send_aw(input logic [AW-1:0] a, input int dly);
        int n = 0;
        repeat (dly) @(negedge clk);
        bus.awaddr = a; bus.awprot = 3'($urandom); bus.awvalid = 1'b1;
        while (!bus.awready && n < BOUND) begin @(negedge clk); n++; end
        chk("aw_handshake_bound", 96'(n < BOUND), 96'(1));
        aw_hs = cyc;
        @(negedge clk);
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [BW-1:0] be, input int dly);
        int n = 0;
        repeat (dly) @(negedge clk);
        bus.wdata = d; bus.wstrb = be; bus.wvalid = 1'b1;
        while (!bus.wready && n < BOUND) begin @(negedge clk); n++; end
        chk("w_handshake_bound", 96'(n < BOUND), 96'(1));
        w_hs = cyc;
        @(negedge clk);
        bus.wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [AW-1:0] a, input int dly);
        int n = 0;
        repeat (dly) @(negedge clk);
        bus.araddr = a; bus.arprot = 3'($urandom); bus.arvalid = 1'b1;
        while (!bus.arready && n < BOUND) begin @(negedge clk); n++; end
        chk("ar_handshake_bound", 96'(n < BOUND), 96'(1));
        ar_hs = cyc;
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] resp, output int c, input int hold);
        int n = 0;
        bit stable = 1'b1;
        while (!bus.bvalid && n < BOUND) begin @(negedge clk); n++; end
        chk("bvalid_bound", 96'(n < BOUND), 96'(1));
        c = cyc; resp = bus.bresp;
        repeat (hold) begin
            @(negedge clk);
            if (!bus.bvalid || bus.bresp !== resp || bus.awready || bus.wready || bus.arready) stable = 1'b0;
        end
        if (hold > 0) chk("b_stall_stable", 96'(stable), 96'(1));
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic get_r(output logic [DW-1:0] d, output logic [1:0] resp, output int c, input int hold);
        int n = 0;
        bit stable = 1'b1;
        while (!bus.rvalid && n < BOUND) begin @(negedge clk); n++; end
        chk("rvalid_bound", 96'(n < BOUND), 96'(1));
        c = cyc; d = bus.rdata; resp = bus.rresp;
        repeat (hold) begin
            @(negedge clk);
            if (!bus.rvalid || bus.rdata !== d || bus.rresp !== resp ||
                bus.awready || bus.wready || bus.arready) stable = 1'b0;
        end
        if (hold > 0) chk("r_stall_stable", 96'(stable), 96'(1));
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    task automatic wr_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be,
                          input int adly, input int wdly, input bit err, input int hold);
        logic [1:0] resp;
        int         bc;
        wr_rec_t    r;
        bus.reg_wr_err = err;
        fork
            send_aw(a, adly);
            send_w(d, be, wdly);
        join
        get_b(resp, bc, hold);
        bus.reg_wr_err = 1'b0;
        chk("wr_strobe_count", 96'(wq.size()), 96'(1));
        if (wq.size() > 0) begin
            r = wq.pop_front();
            chk("wr_addr", 96'(r.addr), 96'(a & ~AW'(BW - 1)));
            chk("wr_data", 96'(r.data), 96'(d));
            chk("wr_be", 96'(r.be), 96'(be));
            chk("wr_latency", 96'(r.c), 96'(((aw_hs > w_hs) ? aw_hs : w_hs) + 2));
            chk("b_latency", 96'(bc), 96'(r.c + 1));
        end
        chk("bresp", 96'(resp), 96'(err ? 2'b10 : 2'b00));
        if (!err) upd_shadow(a, d, be);
        last_wr = 1'b1;
        wq.delete();
    endtask

    task automatic rd_txn(input logic [AW-1:0] a, input int adly, input int rdly, input bit err, input int hold);
        logic [DW-1:0] d;
        logic [1:0]    resp;
        int            rc;
        rd_rec_t       r;
        rd_delay = rdly;
        bus.reg_rd_err = err;
        send_ar(a, adly);
        get_r(d, resp, rc, hold);
        bus.reg_rd_err = 1'b0;
        chk("rd_strobe_count", 96'(rq.size()), 96'(1));
        if (rq.size() > 0) begin
            r = rq.pop_front();
            chk("rd_addr", 96'(r.addr), 96'(a & ~AW'(BW - 1)));
            chk("rd_latency", 96'(r.c), 96'(ar_hs + 2));
            if (rdly < int'(RDT)) begin
                chk("r_latency", 96'(rc), 96'(r.c + rdly + 1));
                chk("rdata", 96'(d), 96'(shadow[a[AW-1:2]]));
                chk("rresp", 96'(resp), 96'(err ? 2'b10 : 2'b00));
            end else begin
                chk("timeout_latency", 96'(rc), 96'(r.c + int'(RDT)));
                chk("timeout_rdata", 96'(d), 96'(0));
                chk("timeout_rresp", 96'(resp), 96'(2'b10));
                repeat (rdly - int'(RDT) + 2) @(negedge clk);
                chk("late_valid_ignored", 96'({bus.rvalid, bus.reg_read, bus.reg_write}), 96'(0));
            end
        end
        last_wr = 1'b0;
        rq.delete();
    endtask

    task automatic pair_txn(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [AW-1:0] ra, input int rdly);
        logic [1:0]    bresp, rresp;
        logic [DW-1:0] rdata, exp_rd;
        int            bc, rc;
        bit            wr_first;
        wr_rec_t       w;
        rd_rec_t       r;
        wr_first = !last_wr;
        rd_delay = rdly;
        fork
            send_aw(wa, 0);
            send_w(wd, BW'('1), 0);
            send_ar(ra, 0);
        join
        fork
            get_b(bresp, bc, 0);
            get_r(rdata, rresp, rc, 0);
        join
        if (wr_first) begin
            upd_shadow(wa, wd, BW'('1));
            exp_rd = shadow[ra[AW-1:2]];
        end else begin
            exp_rd = shadow[ra[AW-1:2]];
            upd_shadow(wa, wd, BW'('1));
        end
        chk("pair_strobe_count", 96'({wq.size(), rq.size()}), 96'({32'd1, 32'd1}));
        if (wq.size() > 0 && rq.size() > 0) begin
            w = wq.pop_front();
            r = rq.pop_front();
            chk("pair_order_write_first", 96'(w.c < r.c), 96'(wr_first));
            chk("pair_first_latency", 96'(wr_first ? w.c : r.c), 96'(aw_hs + 2));
            chk("pair_wr_addr", 96'(w.addr), 96'(wa & ~AW'(BW - 1)));
            chk("pair_rd_addr", 96'(r.addr), 96'(ra & ~AW'(BW - 1)));
        end
        chk("pair_rdata", 96'(rdata), 96'(exp_rd));
        chk("pair_resp", 96'({bresp, rresp}), 96'(4'b0000));
        last_wr = !wr_first;
        wq.delete();
        rq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int            rdly;
        reset = 1'b1;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0;
        bus.bready  = 1'b0; bus.rready = 1'b0;
        bus.reg_wr_err = 1'b0; bus.reg_rd_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 96'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_readies", 96'({bus.awready, bus.wready, bus.arready}), 96'(3'b111));

        wr_txn(11'h104, 32'hA5A5_0001, 4'hF, 0, 3, 1'b0, 0);
        wr_txn(11'h008, 32'h0000_1234, 4'hF, 0, 0, 1'b0, 0);
        rd_txn(11'h008, 0, 2, 1'b0, 0);
        pair_txn(11'h00C, 32'hCAFE_0C0C, 11'h008, 2);
        wr_txn(11'h020, 32'h1111_2222, 4'h3, 2, 0, 1'b0, 0);
        pair_txn(11'h024, 32'h2424_2424, 11'h00E, 3);

        rd_txn(11'h104, 0, 70, 1'b0, 0);
        rd_txn(11'h104, 0, 1, 1'b0, 0);
        rd_txn(11'h020, 0, int'(RDT) - 1, 1'b0, 0);
        rd_txn(11'h020, 0, int'(RDT), 1'b0, 0);

        wr_txn(11'h7FC, 32'hBAD0_0BAD, 4'hF, 0, 0, 1'b1, 0);
        rd_txn(11'h7FC, 0, 1, 1'b1, 0);

        wr_txn(11'h030, 32'h3030_5A5A, 4'hC, 1, 0, 1'b0, 10);
        rd_txn(11'h030, 0, 2, 1'b0, 10);

        for (int i = 0; i < 40; i++) begin
            a = AW'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                wr_txn(a, DW'($urandom), BW'($urandom_range(1, 15)), $urandom_range(0, 3),
                       $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
            end else begin
                rdly = ($urandom_range(0, 9) == 0) ? int'(RDT) - 1 : int'($urandom_range(1, 8));
                rd_txn(a, $urandom_range(0, 2), rdly, ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
            end
        end

        rd_delay = 1000;
        send_ar(11'h020, 0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", outs(), 96'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rq.delete();
        wq.delete();
        last_wr = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_readies", 96'({bus.awready, bus.wready, bus.arready, bus.rvalid}), 96'(4'b1110));
        wr_txn(11'h010, 32'h0101_F00D, 4'hF, 0, 0, 1'b0, 0);
        chk("no_stale_rvalid", 96'(bus.rvalid), 96'(0));
        rd_txn(11'h010, 0, 2, 1'b0, 0);

        chk("strobe_overlap", 96'(overlap), 96'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_reg_bridge.md
Name: axi_lite_reg_bridge

Overview:
- AXI4-Lite slave front end that sits directly downstream of the team's AXI-Lite master/interface bundle.
- Converts AXI-Lite write and read transactions into single-cycle register-bus strobes for the local register file.
- Serialises reads and writes, arbitrates fairly between them, returns OKAY/SLVERR responses, and guards reads with a timeout.

Parameters:
DATA_WIDTH, 32, AXI and register data width (multiple of 8)
ADDR_WIDTH, 11, AXI and register byte-address width
RD_TIMEOUT, 64, cycles to wait for reg_rdata_valid before SLVERR (>=2)

Ports:
clk  in  1  single clock for all logic
reset  in  1  asynchronous, active-high reset
awvalid/awready  in/out  1/1  write-address handshake
awaddr  in  ADDR_WIDTH  write byte address
awprot  in  3  ignored
wvalid/wready  in/out  1/1  write-data handshake
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte enables
bvalid/bready  out/in  1/1  write-response handshake
bresp  out  2  00 OKAY, 10 SLVERR
arvalid/arready  in/out  1/1  read-address handshake
araddr  in  ADDR_WIDTH  read byte address
arprot  in  3  ignored
rvalid/rready  out/in  1/1  read-data handshake
rdata  out  DATA_WIDTH  read data
rresp  out  2  00 OKAY, 10 SLVERR
reg_write  out  1  one-cycle write strobe
reg_read  out  1  one-cycle read strobe
reg_addr  out  ADDR_WIDTH  word-aligned address (low log2(DATA_WIDTH/8) bits forced 0)
reg_wdata  out  DATA_WIDTH  write data
reg_be  out  DATA_WIDTH/8  byte enables
reg_wr_err  in  1  sampled in the reg_write cycle; 1 gives SLVERR
reg_rdata  in  DATA_WIDTH  read data, valid with reg_rdata_valid
reg_rdata_valid  in  1  read completion, >=1 cycle after reg_read
reg_rd_err  in  1  sampled with reg_rdata_valid; 1 gives SLVERR

Behaviour:
- Reset (async assert, sync release): every output 0; FSM to IDLE; aw_held/w_held/ar_held cleared; last_was_write=0; timeout counter 0. Any transaction in flight is dropped with no response.
- Capture: AW, W and AR are each latched into their own holding register on handshake.
  - awready = !aw_held && state==IDLE; likewise wready (w_held) and arready (ar_held).
  - AW and W may arrive in either order or the same cycle.
  - No ready depends combinationally on its valid.
- IDLE arbitration, evaluated each cycle on registered held flags:
  - wr_rdy = aw_held && w_held; rd_rdy = ar_held.
  - Both ready: pick read if last_was_write=1, else write.
  - Only one ready: take it. Neither: stay in IDLE.
- WR_ISSUE (1 cycle):
  - reg_write=1 with reg_addr/reg_wdata/reg_be from the held AW/W.
  - Latch bresp = reg_wr_err ? 10 : 00.
  - Clear aw_held and w_held; set last_was_write=1; go to WR_RESP.
- WR_RESP: bvalid=1 and held stable until bready; on handshake go to IDLE. A single-cycle bvalid&bready handshake is legal.
- RD_ISSUE (1 cycle): reg_read=1 with reg_addr from the held AR; clear ar_held; last_was_write=0; counter=0; go to RD_WAIT.
- RD_WAIT:
  - On reg_rdata_valid: rdata=reg_rdata, rresp = reg_rd_err ? 10 : 00; go to RD_RESP.
  - Else increment counter. At counter==RD_TIMEOUT-1 with no valid: rdata=0, rresp=10, go to RD_RESP.
  - reg_rdata_valid outside RD_WAIT is ignored, including a late response after timeout.
- RD_RESP: rvalid=1, rdata/rresp stable until rready; on handshake go to IDLE.
- Latency:
  - Write: AW/W both held to reg_write is 1 cycle; reg_write to bvalid is 1 cycle.
  - Read: AR handshake to reg_read is 1 cycle; reg_rdata_valid to rvalid is 1 cycle.
- Outstanding: at most one transaction in flight. A new AW/W/AR may be captured only in IDLE, so the bridge holds at most one of each pending.
- The reg_* strobes are never asserted in the same cycle as each other.

Test Plan:
- AW then W 3 cycles later (awaddr=0x104, wdata=0xA5A5_0001, wstrb=0xF) -> one reg_write at 0x104 with reg_be=0xF, bvalid next cycle, bresp=00.
- Same-cycle AW+W+AR (ar 0x008, reg_rdata=0x1234 after 2 cycles) with last_was_write=0 -> write first, then read; rdata=0x1234, rresp=00; a following simultaneous pair is serviced read first.
- Read with reg_rdata_valid never asserted, RD_TIMEOUT=64 -> rvalid 64 cycles after reg_read, rresp=10, rdata=0; a late valid is ignored and the next read is correct.
- reg_wr_err=1 on write to 0x7FC; reg_rd_err=1 on read -> bresp=10 and rresp=10 respectively.
- bready/rready held low for 10 cycles -> bvalid/rvalid and their data stay stable; no new ready asserted until the handshake completes.
- reset asserted during RD_WAIT -> all outputs 0 immediately (async); after release a fresh write to 0x010 completes normally.
